// File: rtl/out_tx_unit_pkg.sv
// rtl/out_tx_unit_pkg.sv - shared TX state encoding and UART frame constants
package out_tx_unit_pkg;

    typedef logic [1:0] tx_state_t;

    localparam tx_state_t TX_IDLE  = 2'd0;
    localparam tx_state_t TX_START = 2'd1;
    localparam tx_state_t TX_DATA  = 2'd2;
    localparam tx_state_t TX_STOP  = 2'd3;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/out_tx_unit_tx_core.sv
// rtl/out_tx_unit_tx_core.sv - 8N1 UART transmitter: FSM, baud counter, shift register
module uart_tx_core
    import out_tx_unit_pkg::*;
#(
    parameter int CLK_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       txd
);

    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_PER_BIT - 1);

    tx_state_t     state;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          baud_done;

    assign baud_done = (baud == BAUD_LAST);
    assign ready     = (state == TX_IDLE);

    // txd is updated together with the state so the line never glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= TX_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= 1'b1;
        end else if (state == TX_IDLE) begin
            if (start) begin
                state <= TX_START;
                baud  <= '0;
                shift <= data;
                txd   <= 1'b0;
            end
        end else if (!baud_done) begin
            baud <= baud + 1'b1;
        end else begin
            baud <= '0;
            case (state)
                TX_START: begin
                    state   <= TX_DATA;
                    bit_idx <= '0;
                    txd     <= shift[0];
                end
                TX_DATA: begin
                    shift <= shift >> 1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        state   <= TX_STOP;
                        bit_idx <= '0;
                        txd     <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        txd     <= shift[1];
                    end
                end
                default: begin
                    if (bit_idx == 3'(STOP_BITS - 1)) begin
                        state <= TX_IDLE;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/out_tx_unit.sv
// rtl/out_tx_unit.sv - OUT byte FIFO with busy handshake feeding a UART transmitter
module out_tx_unit
    import out_tx_unit_pkg::*;
#(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_LOG    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       out_req,
    input  logic [7:0] out_data,
    output logic       out_busy,
    output logic       txd,
    output logic       tx_active
);

    localparam int DEPTH = 1 << FIFO_LOG;

    typedef logic [FIFO_LOG:0] count_t;
    localparam count_t FULL_COUNT = count_t'(DEPTH);

    logic [7:0]          mem [DEPTH];
    logic [FIFO_LOG-1:0] wptr;
    logic [FIFO_LOG-1:0] rptr;
    count_t              count;
    logic                push;
    logic                pop;
    logic                core_ready;

    // busy comes only from the registered count, never from out_req
    assign out_busy  = (count == FULL_COUNT);
    assign push      = out_req & ~out_busy;
    assign pop       = core_ready & (count != '0);
    assign tx_active = ~core_ready | (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= out_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    uart_tx_core #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .start(pop),
        .data (mem[rptr]),
        .ready(core_ready),
        .txd  (txd)
    );

endmodule
